// File: rtl/pcie_seq_pkg.sv
// -----------------------------------------------------------------------------
// pcie_seq_pkg
// Shared types for the PCIe PERST_n / REFCLK sequencer.
//   seq_state_e  : FSM state encoding, also driven out on the STATE port
//   seq_drive_t  : the three link-facing control levels (PERST_n, REFCLK_EN, MON_EN)
//   drive_for()  : control levels that belong to each state
// -----------------------------------------------------------------------------
package pcie_seq_pkg;

    localparam int STATE_W = 3;
    localparam int RETRY_W = 2;

    typedef enum logic [STATE_W-1:0] {
        S_OFF       = 3'd0,
        S_PWR_WAIT  = 3'd1,
        S_CLK_WAIT  = 3'd2,
        S_WAIT_LINK = 3'd3,
        S_ACTIVE    = 3'd4,
        S_HOLD      = 3'd5,
        S_FAILED    = 3'd6
    } seq_state_e;

    typedef struct packed {
        logic perst_n;
        logic refclk_en;
        logic mon_en;
    } seq_drive_t;

    // Refclk runs from CLK_WAIT onwards and is kept on through HOLD/FAILED so a
    // re-release never has to wait for the clock generators again.
    function automatic seq_drive_t drive_for(input seq_state_e s);
        seq_drive_t d;
        d = '0;
        case (s)
            S_CLK_WAIT, S_HOLD, S_FAILED: d.refclk_en = 1'b1;
            S_WAIT_LINK, S_ACTIVE:        d = '{perst_n: 1'b1, refclk_en: 1'b1, mon_en: 1'b1};
            default:                      d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/pcie_seq_timer.sv
// -----------------------------------------------------------------------------
// pcie_seq_timer
// Load / decrement / zero-detect interval counter used for every timed state.
// Ports:
//   CLK, RST  : clock, synchronous active-high reset
//   load      : high in the first cycle of a timed state; load_val is taken
//   load_val  : interval length N in cycles
//   done      : high in the last of the N cycles (also when N is 0 or 1)
// -----------------------------------------------------------------------------
module pcie_seq_timer #(
    parameter int CNT_W = 20
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] remaining;

    // Cycles left in the interval, including the current one. The load value
    // is used directly in the entry cycle so the interval is exactly N cycles.
    assign remaining = load ? load_val : count;
    assign done      = (remaining <= CNT_W'(1));

    always_ff @(posedge CLK) begin
        // NOTE: state registers take non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (RST) begin
            count <= '0;
        end else if (remaining != '0) begin
            count <= remaining - CNT_W'(1);
        end else begin
            count <= '0;  // saturate at zero, never underflow
        end
    end

endmodule

// File: rtl/pcie_perst_sequencer.sv
// -----------------------------------------------------------------------------
// pcie_perst_sequencer
// Sequences power good -> REFCLK_EN -> PERST_n release for one PCIe link and
// its passive monitor, waits for link-up with timeout and bounded retries.
// Ports:
//   CLK, RST   : clock, synchronous active-high reset
//   PWR_GOOD   : supply stable (sync to CLK); low forces OFF from any state
//   RST_REQ    : one-cycle warm-reset request
//   LINK_UP    : link trained (sync to CLK)
//   PERST_n    : fundamental reset, active low
//   REFCLK_EN  : reference-clock generator enable
//   MON_EN     : monitor capture enable (WAIT_LINK / ACTIVE only)
//   STATE      : current FSM state
//   RETRY_CNT  : link-up retries consumed since last good link-up
//   TMO_PULSE  : one-cycle pulse per link-up timeout
//   FAIL       : sticky failure flag, cleared only by RST
// All outputs are registered.
// -----------------------------------------------------------------------------
module pcie_perst_sequencer
    import pcie_seq_pkg::*;
#(
    parameter int T_PVPERL    = 100,
    parameter int T_PERST_CLK = 20,
    parameter int T_PERST_MIN = 10,
    parameter int LINK_TMO    = 1000,
    parameter int MAX_RETRY   = 3,
    parameter int CNT_W       = 20
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               PWR_GOOD,
    input  logic               RST_REQ,
    input  logic               LINK_UP,
    output logic               PERST_n,
    output logic               REFCLK_EN,
    output logic               MON_EN,
    output logic [STATE_W-1:0] STATE,
    output logic [RETRY_W-1:0] RETRY_CNT,
    output logic               TMO_PULSE,
    output logic               FAIL
);

    seq_state_e       state;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_done;

    assign STATE = state;

    pcie_seq_timer #(.CNT_W(CNT_W)) u_timer (
        .CLK      (CLK),
        .RST      (RST),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    function automatic logic [CNT_W-1:0] interval_for(input seq_state_e s);
        case (s)
            S_PWR_WAIT:  return CNT_W'(T_PVPERL);
            S_CLK_WAIT:  return CNT_W'(T_PERST_CLK);
            S_WAIT_LINK: return CNT_W'(LINK_TMO);
            S_HOLD:      return CNT_W'(T_PERST_MIN);
            default:     return '0;
        endcase
    endfunction

    // Every transition goes through here so the registered outputs and the
    // timer load always agree with the state being entered.
    task automatic enter(input seq_state_e s);
        state                          <= s;
        {PERST_n, REFCLK_EN, MON_EN}   <= drive_for(s);
        tmr_load                       <= 1'b1;
        tmr_val                        <= interval_for(s);
    endtask

    always_ff @(posedge CLK) begin
        tmr_load  <= 1'b0;
        TMO_PULSE <= 1'b0;
        if (RST) begin
            state     <= S_OFF;
            PERST_n   <= 1'b0;
            REFCLK_EN <= 1'b0;
            MON_EN    <= 1'b0;
            RETRY_CNT <= '0;
            FAIL      <= 1'b0;
            tmr_val   <= '0;
        end else if (!PWR_GOOD && state != S_OFF) begin
            enter(S_OFF);
            RETRY_CNT <= '0;
        end else if (RST_REQ && (state == S_CLK_WAIT || state == S_WAIT_LINK ||
                                 state == S_ACTIVE   || state == S_FAILED)) begin
            enter(S_HOLD);
            // Leaving FAILED starts a fresh retry budget; warm resets elsewhere
            // keep the count.
            if (state == S_FAILED) RETRY_CNT <= '0;
        end else begin
            case (state)
                S_OFF:      if (PWR_GOOD) enter(S_PWR_WAIT);
                S_PWR_WAIT: if (tmr_done) enter(S_CLK_WAIT);
                S_CLK_WAIT: if (tmr_done) enter(S_WAIT_LINK);
                S_WAIT_LINK: begin
                    // LINK_UP wins over a coincident timeout.
                    if (LINK_UP) begin
                        enter(S_ACTIVE);
                        RETRY_CNT <= '0;
                    end else if (tmr_done) begin
                        TMO_PULSE <= 1'b1;
                        if (RETRY_CNT < RETRY_W'(MAX_RETRY)) begin
                            RETRY_CNT <= RETRY_CNT + RETRY_W'(1);
                            enter(S_HOLD);
                        end else begin
                            FAIL <= 1'b1;
                            enter(S_FAILED);
                        end
                    end
                end
                S_ACTIVE:   if (!LINK_UP) enter(S_HOLD);
                S_HOLD:     if (tmr_done) enter(S_CLK_WAIT);
                S_FAILED:   ;
                default:    enter(S_OFF);
            endcase
        end
    end

endmodule

// File: tb/tb_pcie_perst_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pcie_perst_sequencer
// Table of {inputs held for n cycles, expected outputs after the last cycle},
// routed through a scoreboard queue, followed by hand-written sequences that
// measure PERST_n release latency and warm-reset low time.
// -----------------------------------------------------------------------------
module tb_pcie_perst_sequencer;
    import pcie_seq_pkg::*;

    localparam int T_PVPERL    = 5;
    localparam int T_PERST_CLK = 3;
    localparam int T_PERST_MIN = 2;
    localparam int LINK_TMO    = 8;
    localparam int MAX_RETRY   = 2;

    logic               CLK = 1'b0;
    logic               RST, PWR_GOOD, RST_REQ, LINK_UP;
    logic               PERST_n, REFCLK_EN, MON_EN, TMO_PULSE, FAIL;
    logic [STATE_W-1:0] STATE;
    logic [RETRY_W-1:0] RETRY_CNT;

    pcie_perst_sequencer #(
        .T_PVPERL    (T_PVPERL),
        .T_PERST_CLK (T_PERST_CLK),
        .T_PERST_MIN (T_PERST_MIN),
        .LINK_TMO    (LINK_TMO),
        .MAX_RETRY   (MAX_RETRY),
        .CNT_W       (20)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .PWR_GOOD  (PWR_GOOD),
        .RST_REQ   (RST_REQ),
        .LINK_UP   (LINK_UP),
        .PERST_n   (PERST_n),
        .REFCLK_EN (REFCLK_EN),
        .MON_EN    (MON_EN),
        .STATE     (STATE),
        .RETRY_CNT (RETRY_CNT),
        .TMO_PULSE (TMO_PULSE),
        .FAIL      (FAIL)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int    n;
        int    rst, pwr, req, link;
        int    st, perst, refclk, mon, retry, tmo, fail;
        string name;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input int n, input int rst, input int pwr, input int req,
                       input int link, input int st, input int perst, input int refclk,
                       input int mon, input int retry, input int tmo, input int fail,
                       input string name);
        vec_t v;
        v = '{n, rst, pwr, req, link, st, perst, refclk, mon, retry, tmo, fail, name};
        tbl.push_back(v);
    endtask

    // Inputs are changed and outputs sampled at the falling edge.
    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t v, e;
        int   steps, lows, refclk_low;

        RST = 1'b1; PWR_GOOD = 1'b0; RST_REQ = 1'b0; LINK_UP = 1'b0;

        //   n rst pwr req lnk | st prst rclk mon rty tmo fail
        // Cold boot: PWR_GOOD presented in cycle 0.
        add(2, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, "reset");
        add(5, 0, 1, 0, 0,   1, 0, 0, 0, 0, 0, 0, "pvperl_c5");
        add(1, 0, 1, 0, 0,   2, 0, 1, 0, 0, 0, 0, "refclk_c6");
        add(2, 0, 1, 0, 0,   2, 0, 1, 0, 0, 0, 0, "clkwait_c8");
        add(1, 0, 1, 0, 0,   3, 1, 1, 1, 0, 0, 0, "perst_rel_c9");
        add(3, 0, 1, 0, 0,   3, 1, 1, 1, 0, 0, 0, "waitlink_c12");
        add(1, 0, 1, 0, 1,   4, 1, 1, 1, 0, 0, 0, "active_c13");
        add(3, 0, 1, 0, 1,   4, 1, 1, 1, 0, 0, 0, "active_hold");
        // Warm reset from ACTIVE; RST_REQ in HOLD must not restart it.
        add(1, 0, 1, 1, 1,   5, 0, 1, 0, 0, 0, 0, "warm_hold");
        add(1, 0, 1, 1, 0,   5, 0, 1, 0, 0, 0, 0, "hold_ign_req");
        add(1, 0, 1, 0, 0,   2, 0, 1, 0, 0, 0, 0, "hold_done");
        add(2, 0, 1, 0, 0,   2, 0, 1, 0, 0, 0, 0, "clk_rewait");
        add(1, 0, 1, 0, 0,   3, 1, 1, 1, 0, 0, 0, "warm_release");
        // First timeout.
        add(7, 0, 1, 0, 0,   3, 1, 1, 1, 0, 0, 0, "tmo_last_cyc");
        add(1, 0, 1, 0, 0,   5, 0, 1, 0, 1, 1, 0, "tmo1");
        add(1, 0, 1, 0, 0,   5, 0, 1, 0, 1, 0, 0, "tmo_one_cyc");
        add(4, 0, 1, 0, 0,   3, 1, 1, 1, 1, 0, 0, "retry1_rel");
        // Power drop in WAIT_LINK clears retries.
        add(1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, "pwr_drop");
        add(3, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, "off_idle");
        // Reboot, then three timeouts into FAILED.
        add(6, 0, 1, 0, 0,   2, 0, 1, 0, 0, 0, 0, "reboot_refclk");
        add(3, 0, 1, 0, 0,   3, 1, 1, 1, 0, 0, 0, "reboot_rel");
        add(8, 0, 1, 0, 0,   5, 0, 1, 0, 1, 1, 0, "retry_a1");
        add(5, 0, 1, 0, 0,   3, 1, 1, 1, 1, 0, 0, "retry_a1_rel");
        add(8, 0, 1, 0, 0,   5, 0, 1, 0, 2, 1, 0, "retry_a2");
        add(5, 0, 1, 0, 0,   3, 1, 1, 1, 2, 0, 0, "retry_a2_rel");
        add(8, 0, 1, 0, 0,   6, 0, 1, 0, 2, 1, 1, "failed");
        add(2, 0, 1, 0, 1,   6, 0, 1, 0, 2, 0, 1, "failed_ign_link");
        add(1, 0, 1, 1, 0,   5, 0, 1, 0, 0, 0, 1, "failed_req");
        add(5, 0, 1, 0, 0,   3, 1, 1, 1, 0, 0, 1, "failed_rel");
        // LINK_UP on the timeout cycle wins.
        add(7, 0, 1, 0, 0,   3, 1, 1, 1, 0, 0, 1, "race_last_cyc");
        add(1, 0, 1, 0, 1,   4, 1, 1, 1, 0, 0, 1, "race_linkup");
        // Link loss does not consume a retry.
        add(1, 0, 1, 0, 0,   5, 0, 1, 0, 0, 0, 1, "link_loss");
        add(4, 0, 1, 0, 0,   2, 0, 1, 0, 0, 0, 1, "loss_clkwait");
        add(1, 0, 1, 0, 0,   3, 1, 1, 1, 0, 0, 1, "loss_rel");
        // RST in the middle of CLK_WAIT.
        add(1, 0, 1, 1, 0,   5, 0, 1, 0, 0, 0, 1, "pre_rst_hold");
        add(2, 0, 1, 0, 0,   2, 0, 1, 0, 0, 0, 1, "pre_rst_clk");
        add(1, 1, 1, 0, 0,   0, 0, 0, 0, 0, 0, 0, "rst_mid");
        add(1, 0, 1, 0, 0,   1, 0, 0, 0, 0, 0, 0, "post_rst_pwr");

        foreach (tbl[i]) begin
            v = tbl[i];
            RST      = (v.rst  != 0);
            PWR_GOOD = (v.pwr  != 0);
            RST_REQ  = (v.req  != 0);
            LINK_UP  = (v.link != 0);
            for (int k = 1; k < v.n; k++) step();
            if (v.req != 0) RST_REQ = 1'b0;  // keep the request a single cycle
            if (v.req != 0 && v.n > 1) RST_REQ = 1'b0;
            sb.push_back(v);
            if (v.req != 0 && v.n == 1) RST_REQ = 1'b1;
            step();
            RST_REQ = 1'b0;
            e = sb.pop_front();
            check({e.name, ".STATE"},     int'(STATE),     e.st);
            check({e.name, ".PERST_n"},   int'(PERST_n),   e.perst);
            check({e.name, ".REFCLK_EN"}, int'(REFCLK_EN), e.refclk);
            check({e.name, ".MON_EN"},    int'(MON_EN),    e.mon);
            check({e.name, ".RETRY_CNT"}, int'(RETRY_CNT), e.retry);
            check({e.name, ".TMO_PULSE"}, int'(TMO_PULSE), e.tmo);
            check({e.name, ".FAIL"},      int'(FAIL),      e.fail);
        end

        // Hand sequence 1: first PWR_WAIT cycle (cycle 1) to PERST_n release (cycle 9).
        steps = 0;
        while (PERST_n == 1'b0 && steps < 40) begin
            step();
            steps++;
        end
        check("boot_release_latency", steps, 8);
        LINK_UP = 1'b1;
        step();
        check("hand_active", int'(STATE), int'(S_ACTIVE));

        // Hand sequence 2: warm reset holds PERST_n low exactly 5 cycles, REFCLK_EN stays up.
        RST_REQ = 1'b1;
        step();
        RST_REQ = 1'b0;
        check("warm_perst_low_next", int'(PERST_n), 0);
        lows = 0;
        refclk_low = 0;
        while (PERST_n == 1'b0 && lows < 40) begin
            if (REFCLK_EN == 1'b0) refclk_low++;
            step();
            lows++;
        end
        check("warm_perst_low_cycles", lows, T_PERST_MIN + T_PERST_CLK);
        check("warm_refclk_kept", refclk_low, 0);
        check("warm_retry_kept", int'(RETRY_CNT), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pcie_perst_sequencer.md
Name: pcie_perst_sequencer

Overview:
- Sequences fundamental reset and reference-clock enable for one PCIe link, plus the passive monitor attached to it.
- Drives PERST_n, REFCLK_EN and MON_EN in spec order: power good, then refclk stable, then PERST_n release.
- Waits for link-up with a timeout and retries a bounded number of times.
- Sits in the verification top between the power/reset model and the link (device BFM plus pcie_monitor_with_reset instance).

Parameters:
- T_PVPERL, 100, cycles PWR_GOOD must stay high before REFCLK_EN asserts.
- T_PERST_CLK, 20, cycles REFCLK_EN must be high before PERST_n releases.
- T_PERST_MIN, 10, minimum cycles PERST_n is held low on any re-assertion.
- LINK_TMO, 1000, cycles after PERST_n release to wait for LINK_UP.
- MAX_RETRY, 3, link-up retries before FAIL.
- CNT_W, 20, width of the down-counter; must hold max(T_*, LINK_TMO).

Ports:
- CLK  input  1  sequencer clock.
- RST  input  1  synchronous, active-high reset.
- PWR_GOOD  input  1  supply-stable indication, synchronous to CLK.
- RST_REQ  input  1  single-cycle warm-reset request.
- LINK_UP  input  1  link-trained indication, already synchronised to CLK.
- PERST_n  output  1  fundamental reset to the link and monitor, active low.
- REFCLK_EN  output  1  enables the reference-clock generators (CLK_TX/CLK_RX models).
- MON_EN  output  1  monitor capture enable; high only in WAIT_LINK and ACTIVE.
- STATE  output  3  current FSM state encoding.
- RETRY_CNT  output  2  retries consumed since the last successful link-up.
- TMO_PULSE  output  1  one-cycle pulse on each link-up timeout.
- FAIL  output  1  sticky failure flag; cleared only by RST.

Behaviour:
- Reset values (RST=1 at a CLK edge): STATE=OFF, PERST_n=0, REFCLK_EN=0, MON_EN=0, RETRY_CNT=0, TMO_PULSE=0, FAIL=0, counter=0. All outputs are registered.
- A single down-counter is loaded on state entry. A state's "done" condition is counter==0. Loading N gives exactly N cycles in the state before the transition.
- OFF (0): all outputs low. PWR_GOOD=1 -> PWR_WAIT, load T_PVPERL.
- PWR_WAIT (1): PWR_GOOD=0 -> OFF. Done -> CLK_WAIT, REFCLK_EN=1, load T_PERST_CLK.
- CLK_WAIT (2): PWR_GOOD=0 -> OFF. Done -> WAIT_LINK, PERST_n=1, MON_EN=1, load LINK_TMO.
- WAIT_LINK (3):
  - LINK_UP=1 -> ACTIVE, RETRY_CNT=0.
  - Done without LINK_UP -> TMO_PULSE=1 for one cycle. If RETRY_CNT<MAX_RETRY: RETRY_CNT+1 -> HOLD. Otherwise -> FAILED, FAIL=1.
- ACTIVE (4): LINK_UP=0 (link loss) -> HOLD; RETRY_CNT is not incremented.
- HOLD (5): PERST_n=0, MON_EN=0, REFCLK_EN stays 1, load T_PERST_MIN. Done -> CLK_WAIT with counter reloaded to T_PERST_CLK. PERST_n is therefore low for at least T_PERST_MIN + T_PERST_CLK cycles.
- FAILED (6): PERST_n=0, REFCLK_EN=1, MON_EN=0. Leaves only via RST_REQ (-> HOLD, RETRY_CNT=0, FAIL stays 1) or RST.
- Priority, highest first: RST; PWR_GOOD=0 (any state except OFF -> OFF, all outputs low, RETRY_CNT=0); RST_REQ; state-local conditions.
- RST_REQ in CLK_WAIT, WAIT_LINK or ACTIVE -> HOLD. Ignored in OFF, PWR_WAIT and HOLD (HOLD does not restart).
- LINK_UP and timeout in the same cycle of WAIT_LINK: LINK_UP wins, no TMO_PULSE.
- LINK_UP is ignored outside WAIT_LINK and ACTIVE.
- RETRY_CNT saturates at MAX_RETRY and never wraps.
- A parameter value of 0 gives a one-cycle pass through the state; the counter never underflows.
- RST mid-sequence aborts immediately: PERST_n=0 on the cycle after the RST edge.

Decomposition:
- Shared package pcie_seq_pkg: FSM state enum (3-bit, values above), STATE_W=3, RETRY_W=2.
- One sub-module is natural: pcie_seq_timer, a load/decrement/zero-detect counter of CNT_W bits. The FSM stays in the top.

Test Plan:
Benches use T_PVPERL=5, T_PERST_CLK=3, T_PERST_MIN=2, LINK_TMO=8, MAX_RETRY=2.
- Cold boot: RST released, PWR_GOOD=1 at cycle 0 -> REFCLK_EN=1 at cycle 6, PERST_n=1 and MON_EN=1 at cycle 9. LINK_UP at cycle 12 -> STATE=ACTIVE at 13, RETRY_CNT=0.
- Timeout/retry: LINK_UP held 0 -> TMO_PULSE at ~cycle 18, RETRY_CNT=1, PERST_n low for 5 cycles. After a second timeout RETRY_CNT=2; after the third, FAIL=1, STATE=FAILED, PERST_n=0.
- Warm reset: in ACTIVE pulse RST_REQ -> PERST_n=0 next cycle, REFCLK_EN stays 1, PERST_n returns to 1 exactly 5 cycles later. RETRY_CNT unchanged.
- Power drop: PWR_GOOD=0 during WAIT_LINK -> next cycle STATE=OFF, PERST_n=0, REFCLK_EN=0, MON_EN=0, RETRY_CNT=0.
- Same-cycle race: LINK_UP rises on the cycle the counter hits 0 -> ACTIVE, no TMO_PULSE. Also: RST asserted mid-CLK_WAIT -> all outputs at reset values after one edge.
- Link loss: LINK_UP falls in ACTIVE -> HOLD, RETRY_CNT stays 0, re-release after 5 cycles.
